// File: rtl/surface_scheduler.sv
// Scroll-tick and terrain-transition scheduler: clock divider, Galois LFSR and transition FSM.
// Define SURFACE_SCHED_RAMP_EN to enable the level counter and the divisor ramp.
module surface_scheduler #(
    parameter int          DIV_W       = 26,
    parameter int          DIV_START   = 12_500_000,
    parameter int          DIV_MIN     = 3_125_000,
    parameter int          DIV_STEP    = 312_500,
    parameter int          LEVEL_MOVES = 32,
    parameter int          GAP_INIT    = 8,
    parameter int          DIFF_MIN    = 2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Run,
    output logic       MoveTick,
    output logic       TransitionTick,
    output logic [3:0] TransitionDiff,
    output logic [3:0] Level
);

    localparam logic [15:0]      LFSR_INIT   = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0]      LFSR_MASK   = 16'hB400;
    localparam logic [DIV_W-1:0] DIV_START_V = DIV_W'(DIV_START);
    localparam logic [3:0]       DIFF_MIN_V  = 4'(DIFF_MIN);
    localparam logic [4:0]       GAP_INIT_V  = 5'(GAP_INIT);

    typedef enum logic [1:0] {IDLE, ARM, ISSUE} state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] cur_div;
    logic [4:0]       gap;
    logic [3:0]       raw;
    logic [3:0]       next_diff;
    logic [4:0]       gap_reload;
    logic             wrap;

    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0);
    assign wrap       = Run && (div_cnt == cur_div - DIV_W'(1));
    assign next_diff  = (raw > DIFF_MIN_V) ? raw : DIFF_MIN_V;
    // Reload is at least diff+3 so the downstream generator is idle again before the next request.
    assign gap_reload = {1'b0, next_diff} + 5'd3 + {2'b00, lfsr[2:0]};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state          <= IDLE;
            lfsr           <= LFSR_INIT;
            div_cnt        <= '0;
            gap            <= GAP_INIT_V;
            raw            <= 4'd0;
            MoveTick       <= 1'b0;
            TransitionTick <= 1'b0;
            TransitionDiff <= DIFF_MIN_V;
        end else begin
            MoveTick       <= 1'b0;
            TransitionTick <= 1'b0;
            if (Run) begin
                lfsr     <= lfsr_next;
                div_cnt  <= wrap ? '0 : div_cnt + DIV_W'(1);
                MoveTick <= wrap;
                case (state)
                    IDLE: begin
                        if (gap == 5'd0) begin
                            state <= ARM;
                        end else if (wrap) begin
                            gap <= gap - 5'd1;
                            if (gap == 5'd1) state <= ARM;
                        end
                    end
                    ARM: begin
                        raw   <= lfsr[3:0];
                        state <= ISSUE;
                    end
                    ISSUE: begin
                        // Hold off one cycle if a scroll pulse is due so the two never coincide.
                        if (!wrap) begin
                            TransitionDiff <= next_diff;
                            TransitionTick <= 1'b1;
                            gap            <= gap_reload;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SURFACE_SCHED_RAMP_EN
    localparam int               MC_W        = $clog2(LEVEL_MOVES + 1);
    localparam logic [DIV_W-1:0] DIV_MIN_V   = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_STEP_V  = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0] DIV_FLOOR_V = DIV_W'(DIV_MIN + DIV_STEP);

    logic [MC_W-1:0] move_cnt;

    // The divisor changes only on a wrap, so the period in progress always runs to completion.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            move_cnt <= '0;
            Level    <= 4'd0;
            cur_div  <= DIV_START_V;
        end else if (wrap) begin
            if (move_cnt == MC_W'(LEVEL_MOVES - 1)) begin
                move_cnt <= '0;
                if (Level != 4'd15) Level <= Level + 4'd1;
                cur_div  <= (cur_div > DIV_FLOOR_V) ? cur_div - DIV_STEP_V : DIV_MIN_V;
            end else begin
                move_cnt <= move_cnt + MC_W'(1);
            end
        end
    end
`else
    assign cur_div = DIV_START_V;
    assign Level   = 4'd0;
`endif

endmodule

// File: tb/tb_surface_scheduler.sv
// Bench for surface_scheduler: randomized Run/reset stimulus against an event-level reference model.
module tb_surface_scheduler;

  localparam int DIV_START   = 8;
  localparam int DIV_MIN     = 4;
  localparam int DIV_STEP    = 2;
  localparam int LEVEL_MOVES = 4;
  localparam int GAP_INIT    = 3;
  localparam int DIFF_MIN    = 2;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SURFACE_SCHED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       move_tick;
  logic       transition_tick;
  logic [3:0] transition_diff;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [15:0] m_lfsr;
  int m_edges, m_moves, m_ups, m_gap, m_raw;
  bit m_arm_due, m_issue_due;
  logic       exp_move, exp_tt;
  logic [3:0] exp_diff;
  logic [3:0] exp_q[$];

  // independent DUT-side monitors
  bit have_prev_tt;
  int moves_since_tt;
  int prev_diff;

  surface_scheduler #(
    .DIV_W(26), .DIV_START(DIV_START), .DIV_MIN(DIV_MIN), .DIV_STEP(DIV_STEP),
    .LEVEL_MOVES(LEVEL_MOVES), .GAP_INIT(GAP_INIT), .DIFF_MIN(DIFF_MIN), .SEED(SEED)
  ) dut (
    .Clk(clk), .Rst(rst_n), .Run(run),
    .MoveTick(move_tick), .TransitionTick(transition_tick),
    .TransitionDiff(transition_diff), .Level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int m_period();
    int p;
    if (!RAMP) return DIV_START;
    p = DIV_START - m_ups * DIV_STEP;
    return (p < DIV_MIN) ? DIV_MIN : p;
  endfunction

  function automatic int exp_level();
    if (!RAMP) return 0;
    return (m_ups > 15) ? 15 : m_ups;
  endfunction

  // One clock edge of the reference: moves every m_period() run-edges, transition two run-edges after
  // the move that exhausts the gap (postponed past any move landing on the issue edge).
  task automatic model_step(input logic rst_v, input logic run_v);
    if (!rst_v) begin
      m_lfsr = SEED; m_edges = 0; m_moves = 0; m_ups = 0; m_gap = GAP_INIT; m_raw = 0;
      m_arm_due = 0; m_issue_due = 0;
      exp_move = 0; exp_tt = 0; exp_diff = 4'(DIFF_MIN);
      exp_q.delete();
      return;
    end
    exp_move = 0;
    exp_tt = 0;
    if (!run_v) return;
    m_edges++;
    if (m_edges == m_period()) begin
      exp_move = 1;
      m_edges = 0;
    end
    if (m_issue_due) begin
      if (!exp_move) begin
        exp_diff = 4'((m_raw > DIFF_MIN) ? m_raw : DIFF_MIN);
        m_gap = int'(exp_diff) + 3 + int'(m_lfsr % 8);
        exp_tt = 1;
        exp_q.push_back(exp_diff);
        m_issue_due = 0;
      end
    end else if (m_arm_due) begin
      m_raw = int'(m_lfsr % 16);
      m_arm_due = 0;
      m_issue_due = 1;
    end else if (exp_move) begin
      m_gap--;
      if (m_gap == 0) m_arm_due = 1;
    end
    if (exp_move) begin
      m_moves++;
      if (RAMP && (m_moves % LEVEL_MOVES == 0)) m_ups++;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic cycle();
    logic rst_at_edge;
    rst_at_edge = rst_n;
    @(posedge clk);
    model_step(rst_n, run);
    @(negedge clk);
    cyc++;
    check("move_tick", move_tick, exp_move);
    check("transition_tick", transition_tick, exp_tt);
    check("transition_diff", transition_diff, exp_diff);
    check("level", level, exp_level());
    check("no_overlap", move_tick & transition_tick, 0);
    if (!rst_at_edge) begin
      have_prev_tt = 0;
      moves_since_tt = 0;
    end else begin
      if (move_tick) moves_since_tt++;
      if (transition_tick) begin
        check("diff_range", (transition_diff >= 4'(DIFF_MIN)) ? 1 : 0, 1);
        if (have_prev_tt) check("gap_guard", (moves_since_tt >= prev_diff + 3) ? 1 : 0, 1);
        if (exp_q.size() == 0) check("tt_unexpected", 1, 0);
        else check("tt_diff_q", transition_diff, exp_q.pop_front());
        have_prev_tt = 1;
        prev_diff = int'(transition_diff);
        moves_since_tt = 0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic measure_first_move(input string tag, input int want);
    int n = 0;
    run = 1'b1;
    while (!move_tick && n < 40) begin
      cycle();
      n++;
    end
    check(tag, n, want);
  endtask

  initial begin
    int n;
    int moves;

    // basic ticking, first transition, long continuous run
    run = 1'b1;
    do_reset(3);
    measure_first_move("first_move", DIV_START);
    moves = 1;
    n = 0;
    while (moves < 3 && n < 200) begin
      cycle();
      n++;
      if (transition_tick) check("early_tt", 1, 0);
      if (move_tick) moves++;
    end
    n = 0;
    while (!transition_tick && n < 20) begin
      cycle();
      n++;
    end
    check("tt_latency", n, 2);
    repeat (850) cycle();
    check("level_end", level, RAMP ? 15 : 0);

    // freeze with the divider at 5
    run = 1'b1;
    do_reset(2);
    repeat (5) cycle();
    run = 1'b0;
    repeat (20) cycle();
    measure_first_move("freeze_resume", 3);
    repeat (150) cycle();

    // reset pulse during ARM
    n = 0;
    while (!m_arm_due && n < 300) begin
      cycle();
      n++;
    end
    check("arm_reached", m_arm_due ? 1 : 0, 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_arm_tt", transition_tick, 0);
    check("rst_arm_diff", transition_diff, DIFF_MIN);
    measure_first_move("post_rst_first_move", DIV_START);
    repeat (100) cycle();

    // random Run gaps and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        run = 1'b0;
        repeat ($urandom_range(1, 25)) cycle();
      end
      run = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      cycle();
      rst_n = 1'b1;
    end
    run = 1'b1;
    repeat (300) cycle();

    check("q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
